// File: rtl/apb_param_regfile.sv
// APB slave register bank: DEPTH words, byte strobes, wait states,
// read-only hardware-status window at the top, PSLVERR on bad access.
module apb_param_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int RO_COUNT    = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           select,
  input  logic                           enable,
  input  logic                           write_en,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [DATA_WIDTH/8-1:0]        strobe,
  input  logic [RO_COUNT*DATA_WIDTH-1:0] hw_status,
  output logic                           ready,
  output logic                           slave_error,
  output logic [DATA_WIDTH-1:0]          read_data
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int RWN = DEPTH - RO_COUNT;
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RWN_A = ADDR_WIDTH'(RWN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wait;
  logic [IW-1:0]         r_idx;
  logic                  r_we;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_regs [RWN];
  logic [DATA_WIDTH-1:0] w_words [DEPTH];

  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_err;
  logic                  w_start;
  logic                  w_live;
  logic                  w_hold;
  logic                  w_done;
  logic                  w_commit;

  assign w_word_idx = address >> LSB;
  assign w_err = ((address & AMASK) != '0)
               | (w_word_idx >= DEPTH_A)
               | (write_en & (w_word_idx >= RWN_A));

  assign w_start  = (r_state == S_IDLE) & select & ~enable;
  assign w_live   = (r_state == S_ACCESS) & select & enable;
  assign w_hold   = w_live & (r_wait != 4'd0);
  assign w_done   = w_live & (r_wait == 4'd0);
  assign w_commit = w_done & r_we & ~r_err;

  // Top RO_COUNT words come straight from hardware status
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (g < RWN) begin : g_rw
      assign w_words[g] = r_regs[g];
    end else begin : g_ro
      assign w_words[g] =
        hw_status[(g-RWN)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (select & ~enable) w_next = S_SETUP;
      S_SETUP:  w_next = select ? S_ACCESS : S_IDLE;
      S_ACCESS: begin
        if (~select | ~enable | (r_wait == 4'd0)) begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait  <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      for (int i = 0; i < RWN; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_start) begin
        r_wait  <= 4'(WAIT_STATES);
        r_idx   <= address[LSB +: IW];
        r_we    <= write_en;
        r_err   <= w_err;
        r_wdata <= write_data;
        r_strb  <= strobe;
      end else if (w_hold) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_commit) begin
        for (int i = 0; i < RWN; i++) begin
          for (int b = 0; b < NB; b++) begin
            if (r_idx == IW'(i) && r_strb[b]) begin
              r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    ready       = (r_state == S_ACCESS) && (r_wait == 4'd0);
    slave_error = ready & r_err;
    read_data   = '0;
    if (ready & ~r_err & ~r_we) begin
      read_data = w_words[r_idx];
    end
  end

endmodule

// File: tb/tb_apb_param_regfile.sv
// Bench for apb_param_regfile: three instances (0/2/3 wait states)
// on one shared bus, directed table plus randomized model checks.
module tb_apb_param_regfile;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int ROC   = 2;
  localparam int NI    = 3;
  localparam int WS [NI] = '{0, 2, 3};

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            select;
  logic            enable;
  logic            write_en;
  logic [DW-1:0]   write_data;
  logic [3:0]      strobe;
  logic [ROC*DW-1:0] hw_status;
  logic [NI-1:0]   rdy;
  logic [NI-1:0]   serr;
  logic [DW-1:0]   rdat [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    apb_param_regfile #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .RO_COUNT(ROC), .WAIT_STATES(WS[k])
    ) u_dut (
      .clock(clock), .reset(reset), .address(address),
      .select(select), .enable(enable), .write_en(write_en),
      .write_data(write_data), .strobe(strobe),
      .hw_status(hw_status), .ready(rdy[k]),
      .slave_error(serr[k]), .read_data(rdat[k])
    );
  end

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    int          hold;
    logic        xerr;
    logic [31:0] xrd;
    logic [2:0]  m;
  } vec_t;

  vec_t        tbl [19];
  logic [31:0] mem [NI][DEPTH];
  int          first_c [NI];
  logic        got_err [NI];
  logic [31:0] got_rd [NI];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Setup, enable, then four ACCESS-length slots; select held for `hold` slots.
  task automatic run_xfer(input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s,
                          input int hold);
    for (int k = 0; k < NI; k++) begin
      first_c[k] = 0;
      got_err[k] = 1'b0;
      got_rd[k]  = '0;
    end
    @(posedge clock); #1;
    address = a; write_en = w; write_data = d; strobe = s;
    select = 1'b1; enable = 1'b0;
    @(posedge clock); #1;
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      address    = $urandom;
      write_data = $urandom;
      strobe     = 4'($urandom);
      write_en   = 1'($urandom);
      if (c > hold) begin
        select = 1'b0;
        enable = 1'b0;
      end
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        if (rdy[k] && first_c[k] == 0) begin
          first_c[k] = c;
          got_err[k] = serr[k];
          got_rd[k]  = rdat[k];
        end
      end
    end
    @(posedge clock); #1;
    select = 1'b0;
    enable = 1'b0;
  endtask

  task automatic check_model(input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s,
                             input int hold, input string tag);
    int          idx;
    bit          e;
    bit          done;
    logic [31:0] val;
    idx = int'(a >> 2);
    e = (a % 4 != 0) || (idx >= DEPTH) || (w && idx >= DEPTH - ROC);
    for (int k = 0; k < NI; k++) begin
      done = hold >= WS[k] + 1;
      val = '0;
      if (done && !e && !w) begin
        if (idx >= DEPTH - ROC) val = hw_status[(idx-(DEPTH-ROC))*DW +: DW];
        else val = mem[k][idx];
      end
      chk($sformatf("%s/ws%0d ready_cycle", tag, WS[k]),
          first_c[k], done ? WS[k] + 1 : 0);
      chk($sformatf("%s/ws%0d slverr", tag, WS[k]),
          {31'd0, got_err[k]}, {31'd0, done && e});
      chk($sformatf("%s/ws%0d rdata", tag, WS[k]), got_rd[k], val);
      if (done && w && !e) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem[k][idx][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s/ws%0d ready", tag, WS[k]), {31'd0, rdy[k]}, 0);
      chk($sformatf("%s/ws%0d slverr", tag, WS[k]), {31'd0, serr[k]}, 0);
      chk($sformatf("%s/ws%0d rdata", tag, WS[k]), rdat[k], 0);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++) mem[k][i] = '0;
  endtask

  initial begin
    tbl[0]  = '{32'h00, 1, 32'hA5A5A5A5, 4'hF, 4, 0, 32'h0, 3'b111};
    tbl[1]  = '{32'h00, 0, 32'h0, 4'hF, 4, 0, 32'hA5A5A5A5, 3'b111};
    tbl[2]  = '{32'h04, 1, 32'h12345678, 4'hF, 4, 0, 32'h0, 3'b111};
    tbl[3]  = '{32'h04, 0, 32'h0, 4'hF, 4, 0, 32'h12345678, 3'b111};
    tbl[4]  = '{32'h08, 1, 32'h11223344, 4'hF, 4, 0, 32'h0, 3'b111};
    tbl[5]  = '{32'h08, 1, 32'hDEADBEEF, 4'h5, 4, 0, 32'h0, 3'b111};
    tbl[6]  = '{32'h08, 0, 32'h0, 4'hF, 4, 0, 32'h11AD33EF, 3'b111};
    tbl[7]  = '{32'h38, 1, 32'h77777777, 4'hF, 4, 1, 32'h0, 3'b111};
    tbl[8]  = '{32'h38, 0, 32'h0, 4'hF, 4, 0, 32'hCAFE0001, 3'b111};
    tbl[9]  = '{32'h3C, 0, 32'h0, 4'hF, 4, 0, 32'h0BADF00D, 3'b111};
    tbl[10] = '{32'h40, 0, 32'h0, 4'hF, 4, 1, 32'h0, 3'b111};
    tbl[11] = '{32'h02, 0, 32'h0, 4'hF, 4, 1, 32'h0, 3'b111};
    tbl[12] = '{32'h08, 1, 32'hFFFFFFFF, 4'h0, 4, 0, 32'h0, 3'b111};
    tbl[13] = '{32'h08, 0, 32'h0, 4'hF, 4, 0, 32'h11AD33EF, 3'b111};
    tbl[14] = '{32'h0C, 1, 32'h000055AA, 4'hF, 1, 0, 32'h0, 3'b110};
    tbl[15] = '{32'h0C, 0, 32'h0, 4'hF, 4, 0, 32'h0, 3'b110};
    tbl[16] = '{32'h3C, 1, 32'h12121212, 4'hF, 4, 1, 32'h0, 3'b111};
    tbl[17] = '{32'h05, 1, 32'h34343434, 4'hF, 4, 1, 32'h0, 3'b111};
    tbl[18] = '{32'h04, 0, 32'h0, 4'hF, 4, 0, 32'h12345678, 3'b111};

    reset = 1'b1; select = 1'b0; enable = 1'b0; write_en = 1'b0;
    address = '0; write_data = '0; strobe = '0;
    hw_status = {32'h0BADF00D, 32'hCAFE0001};
    clear_model();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle("reset");

    for (int v = 0; v < 19; v++) begin
      run_xfer(tbl[v].a, tbl[v].w, tbl[v].d, tbl[v].s, tbl[v].hold);
      for (int k = 0; k < NI; k++) begin
        if (tbl[v].m[k]) begin
          chk($sformatf("vec%0d/ws%0d err", v, WS[k]),
              {31'd0, got_err[k]}, {31'd0, tbl[v].xerr});
          chk($sformatf("vec%0d/ws%0d rd", v, WS[k]),
              got_rd[k], tbl[v].xrd);
        end
      end
      check_model(tbl[v].a, tbl[v].w, tbl[v].d, tbl[v].s, tbl[v].hold,
                  $sformatf("vec%0d", v));
    end

    // Reset lands on the first ACCESS cycle of a write to word 0
    @(posedge clock); #1;
    address = 32'h0; write_en = 1'b1; write_data = 32'hFFFFFFFF;
    strobe = 4'hF; select = 1'b1; enable = 1'b0;
    @(posedge clock); #1;
    enable = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; select = 1'b0; enable = 1'b0;
    @(negedge clock);
    check_idle("rst_access");
    clear_model();
    run_xfer(32'h0, 1'b0, 32'h0, 4'hF, 4);
    for (int k = 0; k < NI; k++)
      chk($sformatf("rst_rd0/ws%0d", WS[k]), got_rd[k], 32'h0);
    check_model(32'h0, 1'b0, 32'h0, 4'hF, 4, "rst_rd0");

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic [3:0]  s;
      int          hold;
      a = 32'($urandom_range(0, 17) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      w = 1'($urandom);
      d = $urandom;
      s = 4'($urandom);
      hold = ($urandom_range(0, 4) == 0) ? 1 : 4;
      if ($urandom_range(0, 9) == 0) hw_status = {$urandom, $urandom};
      run_xfer(a, w, d, s, hold);
      check_model(a, w, d, s, hold, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
